// File: rtl/freq_counter_multi.sv
// freq_counter_multi: multi-channel frequency counter with a small register
// interface. Counts rising edges of one selected channel over 2^k gate
// windows and reports average, minimum and maximum count per window.
module freq_counter_multi #(
  parameter int unsigned NUM_CH      = 24,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned MAX_LOG2    = 7,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              Clock,
  input  logic              nResetIn,
  input  logic [NUM_CH-1:0] in_signal,
  input  logic [ADDR_W-1:0] address,
  input  logic              wr_enable,
  input  logic [15:0]       mem_read,
  input  logic              rd_enable,
  output logic [15:0]       mem_write,
  output logic              irq_out
);

  localparam int unsigned SUM_W  = CNT_W + MAX_LOG2;
  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned IDX_W  = MAX_LOG2 + 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [5:0]        NUM_CH_L  = 6'(NUM_CH);
  localparam logic [2:0]        MAX_K     = 3'(MAX_LOG2);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LOG2N  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_AVG    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_MIN    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_MAX    = ADDR_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              irq_en_q, irq_en_d;
  logic [4:0]        chan_reg_q, chan_reg_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              chan_err_q, chan_err_d;
  logic [2:0]        k_reg_q, k_reg_d;
  logic [4:0]        chan_sel_q, chan_sel_d;
  logic [2:0]        k_run_q, k_run_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic [1:0]        settle_q, settle_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  res_avg_q, res_avg_d;
  logic [CNT_W-1:0]  res_min_q, res_min_d;
  logic [CNT_W-1:0]  res_max_q, res_max_d;
  logic [15:0]       rdata_q, rdata_d;

  logic              busy;
  logic              sel_bit;
  logic              rise;
  logic              wr_ctrl, wr_status, wr_log2n;
  logic              start_req, chan_ok;
  logic [4:0]        start_ch;
  logic [IDX_W-1:0]  idx_inc;
  logic              unused_wdata;

  assign busy      = (state_q != S_IDLE);
  assign rise      = sync2_q & ~prev_q;
  assign wr_ctrl   = wr_enable && (address == A_CTRL);
  assign wr_status = wr_enable && (address == A_STATUS);
  assign wr_log2n  = wr_enable && (address == A_LOG2N);
  assign start_ch  = mem_read[12:8];
  assign start_req = wr_ctrl && mem_read[0] && !busy;
  assign chan_ok   = ({1'b0, start_ch} < NUM_CH_L);
  assign idx_inc   = idx_q + IDX_W'(1);

  assign unused_wdata = ^{mem_read[15:13], mem_read[7:2]};

  assign mem_write = rdata_q;
  assign irq_out   = done_q & irq_en_q;

  // Channel mux driven by the selection latched at start.
  always_comb begin
    sel_bit = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (chan_sel_q == 5'(i)) sel_bit = in_signal[i];
    end
  end

  // Next-state for registers, synchroniser and measurement FSM.
  always_comb begin
    state_d    = state_q;
    irq_en_d   = irq_en_q;
    chan_reg_d = chan_reg_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    chan_err_d = chan_err_q;
    k_reg_d    = k_reg_q;
    chan_sel_d = chan_sel_q;
    k_run_d    = k_run_q;
    sync1_d    = sel_bit;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    settle_d   = settle_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    idx_d      = idx_q;
    res_avg_d  = res_avg_q;
    res_min_d  = res_min_q;
    res_max_d  = res_max_q;

    if (wr_ctrl) begin
      irq_en_d   = mem_read[1];
      chan_reg_d = mem_read[12:8];
    end
    if (wr_status) begin
      if (mem_read[1]) done_d     = 1'b0;
      if (mem_read[2]) ovf_d      = 1'b0;
      if (mem_read[3]) chan_err_d = 1'b0;
    end
    if (wr_log2n) begin
      k_reg_d = (mem_read[2:0] > MAX_K) ? MAX_K : mem_read[2:0];
    end
    if (start_req && !chan_ok) chan_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_req && chan_ok) begin
          chan_sel_d = start_ch;
          k_run_d    = k_reg_q;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
          settle_d   = '0;
          gate_d     = '0;
          edge_d     = '0;
          sum_d      = '0;
          idx_d      = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q + 2'd1;
        if (settle_q == 2'd3) state_d = S_GATE;
      end
      S_GATE: begin
        if (rise) begin
          if (edge_q == CNT_MAX) ovf_d = 1'b1;
          else edge_d = edge_q + CNT_W'(1);
        end
        if (gate_q == GATE_LAST) begin
          gate_d  = '0;
          state_d = S_ACCUM;
        end else begin
          gate_d = gate_q + GATE_W'(1);
        end
      end
      S_ACCUM: begin
        sum_d = sum_q + SUM_W'(edge_q);
        if (idx_q == '0) begin
          min_d = edge_q;
          max_d = edge_q;
        end else begin
          if (edge_q < min_q) min_d = edge_q;
          if (edge_q > max_q) max_d = edge_q;
        end
        idx_d  = idx_inc;
        edge_d = '0;
        if (idx_inc == (IDX_W'(1) << k_run_q)) state_d = S_DONE;
        else state_d = S_GATE;
      end
      S_DONE: begin
        // Average is taken from the final sum here so results publish atomically.
        res_avg_d = CNT_W'(sum_q >> k_run_q);
        res_min_d = min_q;
        res_max_d = max_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered read data; sampled from pre-write register values.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_enable) begin
      rdata_d = '0;
      if (address == A_CTRL) begin
        rdata_d[1]    = irq_en_q;
        rdata_d[12:8] = chan_reg_q;
      end else if (address == A_STATUS) begin
        rdata_d[3:0] = {chan_err_q, ovf_q, done_q, busy};
      end else if (address == A_LOG2N) begin
        rdata_d[2:0] = k_reg_q;
      end else if (address == A_AVG) begin
        rdata_d = 16'(res_avg_q);
      end else if (address == A_MIN) begin
        rdata_d = 16'(res_min_q);
      end else if (address == A_MAX) begin
        rdata_d = 16'(res_max_q);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q    <= S_IDLE;
      irq_en_q   <= 1'b0;
      chan_reg_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      chan_err_q <= 1'b0;
      k_reg_q    <= '0;
      chan_sel_q <= '0;
      k_run_q    <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      settle_q   <= '0;
      gate_q     <= '0;
      edge_q     <= '0;
      sum_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      res_avg_q  <= '0;
      res_min_q  <= '0;
      res_max_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      irq_en_q   <= irq_en_d;
      chan_reg_q <= chan_reg_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      chan_err_q <= chan_err_d;
      k_reg_q    <= k_reg_d;
      chan_sel_q <= chan_sel_d;
      k_run_q    <= k_run_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      res_avg_q  <= res_avg_d;
      res_min_q  <= res_min_d;
      res_max_q  <= res_max_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: doc/freq_counter_multi.md
Name: freq_counter_multi

Overview:
- Parametrised multi-channel frequency counter for Cyclone IV chip-tester FPGA; measures a selected device output over a programmable number of fixed gate windows.
- Reports average, minimum and maximum edge count through a small register interface; raises an interrupt on completion.
- Replaces the fixed-width counter/buffer/control set with one configurable block.

Parameters:
- NUM_CH, 24, number of input channels (1..32).
- CNT_W, 16, width of per-window edge count.
- GATE_CYCLES, 50000, Clock cycles per gate window (>=8).
- MAX_LOG2, 7, maximum log2 of sample count.
- ADDR_W, 6, register address width.

Ports:
- Clock  input  1  system clock.
- nResetIn  input  1  asynchronous active-low reset.
- in_signal  input  NUM_CH  asynchronous device outputs.
- address  input  ADDR_W  register address.
- wr_enable  input  1  register write strobe.
- mem_read  input  16  write data from host.
- rd_enable  input  1  register read strobe.
- mem_write  output  16  read data to host, valid cycle after rd_enable.
- irq_out  output  1  completion interrupt, level.

Behaviour:
- Reset: all registers 0, FSM IDLE, mem_write=0, irq_out=0.
- Registers:
  - 0 CTRL: [0] start (self-clearing), [1] irq_en, [12:8] channel.
  - 1 STATUS: [0] busy (RO), [1] done (W1C), [2] overflow (W1C), [3] chan_err (W1C).
  - 2 LOG2N: [2:0] k, values >MAX_LOG2 clamp to MAX_LOG2.
  - 3 AVG, 4 MIN, 5 MAX: RO, lower CNT_W bits, upper bits 0.
  - Other addresses read 0, writes ignored.
- Read: mem_write registered, updated cycle after rd_enable, otherwise holds. Same-cycle read and write to one address returns pre-write value.
- Input path: selected channel through 2-FF synchroniser plus edge register. Rising edge = prev 0, cur 1. Mux selection is latched at start.
- Start, valid channel <NUM_CH, not busy: latch channel and k, clear done/overflow, go SETTLE.
- Start, channel >=NUM_CH: set chan_err, stay IDLE.
- Start while busy: ignored.
- FSM:
  - IDLE.
  - SETTLE: 4 cycles to flush synchroniser, edges ignored. Then GATE.
  - GATE: gate counter 0..GATE_CYCLES-1; edge counter increments per rising edge and saturates at 2^CNT_W-1 (sets overflow). On last cycle go ACCUM.
  - ACCUM, 1 cycle:
    - sum += count, with sum width CNT_W+MAX_LOG2.
    - Update min/max; first sample initialises both.
    - Increment sample index.
    - If index==2^k: AVG=sum>>k (truncate), go DONE. Else clear edge counter, go GATE with no settle gap.
  - DONE, 1 cycle: set done, go IDLE.
- An edge in the ACCUM cycle is dropped; documented measurement dead-time is 1 cycle per window.
- busy=1 in SETTLE/GATE/ACCUM/DONE.
- irq_out = done & irq_en, combinational from registers. Clearing done or irq_en drops it the next cycle.
- AVG/MIN/MAX keep the previous result until DONE of the next run; they are never partially updated.
- Reset mid-measurement aborts immediately; all state returns to reset values.

Test Plan:
- GATE_CYCLES=100, channel 3 = Clock/10, k=0, irq_en=1, start -> done after 4+100+1+1 cycles; AVG=MIN=MAX=10; irq_out=1; write STATUS=0x2 -> irq_out=0 next cycle.
- k=3, channel 0 toggled with alternating 9/11 edges per window -> AVG=10, MIN=9, MAX=11, done after 8 windows.
- CNT_W=4, input = Clock/2 (50 edges/window) -> count saturates 15, overflow=1, AVG=15.
- CTRL channel=30 with NUM_CH=24 -> chan_err=1, busy stays 0, no irq.
- Second start during GATE, then nResetIn pulse mid-GATE -> second start ignored; after reset all registers read 0, mem_write=0, irq_out=0.
- rd_enable and wr_enable same cycle on LOG2N (old 2, new 5) -> mem_write=2 next cycle, subsequent read=5; LOG2N write of 7 with MAX_LOG2=5 -> run uses 32 samples.
